// File: rtl/wbpico_slave.sv
// wbpico_slave: Wishbone pipelined slave bridging onto a picorv32-style
// native valid/ready memory target. One transaction in flight at a time;
// the bus is stalled while it is outstanding, and a silent target is turned
// into a Wishbone error by a timeout counter.
//
// Handshakes:
//   Wishbone side: a request is taken in any cycle where i_wb_cyc && i_wb_stb
//   && !o_wb_stall. Completion is a single-cycle o_wb_ack (read data valid on
//   o_wb_data in that cycle) or a single-cycle o_wb_err, never both.
//   Native side: o_mem_valid rises with addr/wdata/wstrb stable and stays high
//   until a cycle with i_mem_ready (or a timeout); i_mem_ready is looked at
//   only while o_mem_valid is high.
//
// TIMEOUT_CYCLES must be below 2**CW; 0 disables the timeout.

module wbpico_slave #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CW             = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // Wishbone pipelined slave port
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_wb_err,
  // Native memory master port
  output logic        o_mem_valid,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  // Current FSM state, for observation only
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // ready to accept a request
    ST_BUSY  = 2'd1,  // native request issued, bus still attached
    ST_ABORT = 2'd2   // native request issued, bus cycle already dropped
  } state_t;

  // Counter value on the last silent cycle before the request is abandoned.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic          mem_valid_d;
  logic          stall_d;
  logic          ack_d;
  logic          err_d;
  logic          capture;
  logic          load_rdata;
  logic          we_q;
  logic          timeout_hit;

  assign o_state = state;

  // The target has been silent for TIMEOUT_CYCLES cycles once this cycle ends.
  assign timeout_hit = TO_EN && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_d;
  end

  // Next-state and next-output decisions; ready beats a same-cycle timeout.
  always_comb begin
    state_d     = state;
    mem_valid_d = o_mem_valid;
    stall_d     = o_wb_stall;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt;
    capture     = 1'b0;
    load_rdata  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          capture = 1'b1;
          if (i_wb_we && (i_wb_sel == 4'h0)) begin
            // A write touching no bytes completes without bothering the target.
            ack_d = 1'b1;
          end else begin
            state_d     = ST_BUSY;
            mem_valid_d = 1'b1;
            stall_d     = 1'b1;
            cnt_d       = '0;
          end
        end
      end
      ST_BUSY: begin
        if (i_mem_ready) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          stall_d     = 1'b0;
          // If the master left in this very cycle, nobody is there to ack.
          if (i_wb_cyc) begin
            ack_d      = 1'b1;
            load_rdata = !we_q;
          end
        end else if (timeout_hit) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          stall_d     = 1'b0;
          err_d       = i_wb_cyc;
        end else begin
          if (TO_EN) cnt_d = cnt + CNT_ONE;
          // Valid may not be withdrawn before ready, so keep waiting detached.
          if (!i_wb_cyc) state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (i_mem_ready || timeout_hit) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          stall_d     = 1'b0;
        end else if (TO_EN) begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
        stall_d     = 1'b0;
      end
    endcase
  end

  // Control registers: handshake flags, completion pulses and timeout counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_mem_valid <= 1'b0;
      o_wb_stall  <= 1'b0;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      cnt         <= '0;
    end else begin
      o_mem_valid <= mem_valid_d;
      o_wb_stall  <= stall_d;
      o_wb_ack    <= ack_d;
      o_wb_err    <= err_d;
      cnt         <= cnt_d;
    end
  end

  // Request capture; only loads in IDLE, so it is frozen while valid is high.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
      we_q        <= 1'b0;
    end else if (capture) begin
      o_mem_addr  <= {i_wb_addr, 2'b00};
      o_mem_wdata <= i_wb_data;
      o_mem_wstrb <= i_wb_we ? i_wb_sel : 4'h0;
      we_q        <= i_wb_we;
    end
  end

  // Read data register; updated only alongside a read acknowledge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)         o_wb_data <= '0;
    else if (load_rdata) o_wb_data <= i_mem_rdata;
  end

  // Completion pulses are exclusive.
  a_ack_err_excl: assert property (@(posedge i_clk) disable iff (i_reset)
    !(o_wb_ack && o_wb_err));

  // Native request fields do not move while a request is outstanding.
  a_req_stable: assert property (@(posedge i_clk) disable iff (i_reset)
    (o_mem_valid && $past(o_mem_valid)) |->
      ($stable(o_mem_addr) && $stable(o_mem_wdata) && $stable(o_mem_wstrb)));

endmodule

// File: tb/tb_wbpico_slave.sv
// Directed bench for wbpico_slave. Two instances share the stimulus: dut uses
// the default timeout, tdut uses TIMEOUT_CYCLES=4 for the timeout scenarios.
// Inputs change 1ns after a rising edge; outputs are checked at that point,
// so "cycle n" below is the clock period that starts with rising edge n.

module tb_wbpico_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        stall, ack, err, mem_valid;
  logic [31:0] wb_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  state;

  logic        t_stall, t_ack, t_err, t_mem_valid;
  logic [31:0] t_wb_rdata, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_wstrb;
  logic [1:0]  t_state;

  int vectors = 0;
  int miscompares = 0;

  wbpico_slave dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(wb_rdata), .o_wb_err(err),
    .o_mem_valid(mem_valid), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wstrb(mem_wstrb), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_state(state)
  );

  wbpico_slave #(.TIMEOUT_CYCLES(4), .CW(8)) tdut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(t_stall), .o_wb_ack(t_ack), .o_wb_data(t_wb_rdata), .o_wb_err(t_err),
    .o_mem_valid(t_mem_valid), .o_mem_addr(t_mem_addr), .o_mem_wdata(t_mem_wdata),
    .o_mem_wstrb(t_mem_wstrb), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_state(t_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000ns");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    cyc = 0; stb = 0; we = 0; addr = '0; wdata = '0; sel = '0;
    mem_ready = 0; mem_rdata = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if ({stall, ack, err, mem_valid} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000", {stall, ack, err, mem_valid}); end
    vectors++; if ({wb_rdata, mem_addr, mem_wdata, mem_wstrb} !== 100'd0) begin
      miscompares++; $display("FAIL reset_data: got %h want 0", {wb_rdata, mem_addr, mem_wdata, mem_wstrb}); end
    vectors++; if (state !== 2'd0) begin
      miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
    vectors++; if ({t_stall, t_ack, t_err, t_mem_valid} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_tflags: got %b want 0000", {t_stall, t_ack, t_err, t_mem_valid}); end
  endtask

  task automatic test_read();
    apply_reset();
    // cycle 0: present read of word 0x10
    cyc = 1; stb = 1; we = 0; addr = 30'h10;
    vectors++; if (stall !== 1'b0) begin
      miscompares++; $display("FAIL read_c0_stall: got %b want 0", stall); end
    step();
    stb = 0; addr = 30'h3FF;  // bus address moves; captured address must not
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin mem_ready = 1; mem_rdata = 32'hDEADBEEF; end
      vectors++; if ({mem_valid, stall, ack, err} !== 4'b1100) begin
        miscompares++; $display("FAIL read_c%0d_flags: got %b want 1100", c, {mem_valid, stall, ack, err}); end
      vectors++; if (mem_addr !== 32'h40 || mem_wstrb !== 4'h0) begin
        miscompares++; $display("FAIL read_c%0d_req: got %h/%h want 00000040/0", c, mem_addr, mem_wstrb); end
      step();
    end
    mem_ready = 0;
    // cycle 5: ack with data
    vectors++; if ({mem_valid, stall, ack, err} !== 4'b0010) begin
      miscompares++; $display("FAIL read_c5_flags: got %b want 0010", {mem_valid, stall, ack, err}); end
    vectors++; if (wb_rdata !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL read_c5_data: got %h want deadbeef", wb_rdata); end
    step();
    vectors++; if (ack !== 1'b0) begin
      miscompares++; $display("FAIL read_c6_ack: got %b want 0", ack); end
    cyc = 0;
  endtask

  task automatic test_write();
    // continues from the read: o_wb_data holds DEADBEEF
    cyc = 1; stb = 1; we = 1; addr = 30'h21; wdata = 32'h12345678; sel = 4'b0011;
    step();
    stb = 0; wdata = 32'hFFFFFFFF; sel = 4'hF; mem_ready = 1;
    vectors++; if (mem_valid !== 1'b1 || mem_wstrb !== 4'b0011 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h84) begin
      miscompares++; $display("FAIL write_c1_req: got v=%b %h %h %h want v=1 3 12345678 00000084", mem_valid, mem_wstrb, mem_wdata, mem_addr); end
    vectors++; if (ack !== 1'b0) begin
      miscompares++; $display("FAIL write_c1_ack: got %b want 0", ack); end
    step();
    mem_ready = 0;
    vectors++; if ({mem_valid, stall, ack, err} !== 4'b0010) begin
      miscompares++; $display("FAIL write_c2_flags: got %b want 0010", {mem_valid, stall, ack, err}); end
    vectors++; if (wb_rdata !== 32'hDEADBEEF || mem_wdata !== 32'h12345678) begin
      miscompares++; $display("FAIL write_c2_hold: got %h/%h want deadbeef/12345678", wb_rdata, mem_wdata); end
    // zero-select write
    stb = 1; we = 1; sel = 4'h0; addr = 30'h5; wdata = 32'hCAFEF00D;
    step();
    stb = 0;
    vectors++; if ({mem_valid, stall, ack, err} !== 4'b0010) begin
      miscompares++; $display("FAIL zsel_c1_flags: got %b want 0010", {mem_valid, stall, ack, err}); end
    vectors++; if (mem_wstrb !== 4'h0 || state !== 2'd0) begin
      miscompares++; $display("FAIL zsel_c1_idle: got %h/%0d want 0/0", mem_wstrb, state); end
    step();
    vectors++; if ({mem_valid, ack} !== 2'b00) begin
      miscompares++; $display("FAIL zsel_c2: got %b want 00", {mem_valid, ack}); end
    cyc = 0; we = 0;
  endtask

  task automatic test_timeout();
    apply_reset();
    // silent target
    cyc = 1; stb = 1; we = 0; addr = 30'h1;
    step();
    stb = 0;
    for (int c = 1; c <= 4; c++) begin
      vectors++; if ({t_mem_valid, t_ack, t_err} !== 3'b100) begin
        miscompares++; $display("FAIL to_c%0d: got %b want 100", c, {t_mem_valid, t_ack, t_err}); end
      step();
    end
    vectors++; if ({t_mem_valid, t_stall, t_ack, t_err} !== 4'b0001) begin
      miscompares++; $display("FAIL to_c5: got %b want 0001", {t_mem_valid, t_stall, t_ack, t_err}); end
    step();
    vectors++; if (t_err !== 1'b0) begin
      miscompares++; $display("FAIL to_c6_err: got %b want 0", t_err); end
    // ready on the terminal cycle wins
    stb = 1; addr = 30'h2;
    step();
    stb = 0;
    repeat (3) step();
    mem_ready = 1; mem_rdata = 32'h0BADF00D;
    vectors++; if (t_mem_valid !== 1'b1) begin
      miscompares++; $display("FAIL to_race_c4_valid: got %b want 1", t_mem_valid); end
    step();
    mem_ready = 0;
    vectors++; if ({t_mem_valid, t_ack, t_err} !== 3'b010) begin
      miscompares++; $display("FAIL to_race_c5: got %b want 010", {t_mem_valid, t_ack, t_err}); end
    vectors++; if (t_wb_rdata !== 32'h0BADF00D) begin
      miscompares++; $display("FAIL to_race_data: got %h want 0badf00d", t_wb_rdata); end
    cyc = 0;
  endtask

  task automatic test_abort();
    apply_reset();
    cyc = 1; stb = 1; we = 0; addr = 30'h7;
    step();
    cyc = 0; stb = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) begin mem_ready = 1; mem_rdata = 32'h55; end
      vectors++; if ({mem_valid, stall, ack, err} !== 4'b1100) begin
        miscompares++; $display("FAIL abort_c%0d: got %b want 1100", c, {mem_valid, stall, ack, err}); end
      if (c >= 2) begin
        vectors++; if (state !== 2'd2) begin
          miscompares++; $display("FAIL abort_c%0d_state: got %0d want 2", c, state); end
      end
      step();
    end
    mem_ready = 0;
    vectors++; if ({mem_valid, stall, ack, err} !== 4'b0000 || wb_rdata !== 32'h0) begin
      miscompares++; $display("FAIL abort_c7: got %b/%h want 0000/0", {mem_valid, stall, ack, err}, wb_rdata); end
    // next request proceeds normally
    cyc = 1; stb = 1; addr = 30'h8;
    step();
    stb = 0; mem_ready = 1; mem_rdata = 32'h600D;
    vectors++; if (mem_valid !== 1'b1 || mem_addr !== 32'h20) begin
      miscompares++; $display("FAIL abort_next_req: got %b/%h want 1/00000020", mem_valid, mem_addr); end
    step();
    mem_ready = 0;
    vectors++; if (ack !== 1'b1 || wb_rdata !== 32'h600D) begin
      miscompares++; $display("FAIL abort_next_ack: got %b/%h want 1/0000600d", ack, wb_rdata); end
    cyc = 0;
  endtask

  task automatic test_back_to_back();
    int acks;
    apply_reset();
    acks = 0;
    cyc = 1; we = 0; mem_ready = 1;  // zero-wait target
    for (int n = 0; n < 4; n++) begin
      stb = 1; addr = 30'h100 + 30'(n);
      vectors++; if (stall !== 1'b0) begin
        miscompares++; $display("FAIL b2b_%0d_stall: got %b want 0", n, stall); end
      step();
      stb = 0; mem_rdata = 32'h10000000 + n;
      vectors++; if (mem_valid !== 1'b1 || mem_addr !== {30'h100 + 30'(n), 2'b00}) begin
        miscompares++; $display("FAIL b2b_%0d_req: got %b/%h want 1/%h", n, mem_valid, mem_addr, {30'h100 + 30'(n), 2'b00}); end
      step();
      if (ack === 1'b1) acks++;
      vectors++; if (ack !== 1'b1 || wb_rdata !== 32'h10000000 + n) begin
        miscompares++; $display("FAIL b2b_%0d_ack: got %b/%h want 1/%h", n, ack, wb_rdata, 32'h10000000 + n); end
    end
    vectors++; if (acks != 4) begin
      miscompares++; $display("FAIL b2b_count: got %0d want 4", acks); end
    // reset in the middle of a BUSY request
    mem_ready = 0; stb = 1; addr = 30'h200;
    step();
    stb = 0;
    vectors++; if (mem_valid !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_pre: got %b want 1", mem_valid); end
    #2 rst = 1;
    #1;
    vectors++; if ({stall, ack, err, mem_valid} !== 4'b0000 || {wb_rdata, mem_addr, mem_wdata, mem_wstrb} !== 100'd0) begin
      miscompares++; $display("FAIL rst_mid_async: got %b/%h want 0000/0", {stall, ack, err, mem_valid}, mem_addr); end
    step();
    rst = 0;
    // first post-reset read
    stb = 1; addr = 30'h33;
    step();
    stb = 0; mem_ready = 1; mem_rdata = 32'h1234ABCD;
    vectors++; if (mem_valid !== 1'b1 || mem_addr !== 32'hCC) begin
      miscompares++; $display("FAIL post_rst_req: got %b/%h want 1/000000cc", mem_valid, mem_addr); end
    step();
    mem_ready = 0;
    vectors++; if (ack !== 1'b1 || wb_rdata !== 32'h1234ABCD) begin
      miscompares++; $display("FAIL post_rst_ack: got %b/%h want 1/1234abcd", ack, wb_rdata); end
    cyc = 0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_abort();
    test_back_to_back();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wbpico_slave.md
# wbpico_slave

Wishbone pipelined slave that bridges onto a picorv32-style native memory target: valid/addr/wdata/wstrb out, ready/rdata in. It lets peripherals written for the native valid/ready handshake sit on the same Wishbone bus that the CPU bridge drives. It accepts one transaction at a time, stalls the bus while that transaction is in flight, and converts target silence into a Wishbone error via a timeout counter.

## Interface
- TIMEOUT_CYCLES, 255: cycles with o_mem_valid high and no i_mem_ready before the block errors the request. 0 disables the timeout.
- CW, 8: timeout counter width. Must satisfy TIMEOUT_CYCLES < 2^CW.

Ports:
- i_clk  in  1  single clock; all logic on posedge.
- i_reset  in  1  asynchronous, active-high reset.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  request strobe.
- i_wb_we  in  1  write enable.
- i_wb_addr  in  30  word address.
- i_wb_data  in  32  write data.
- i_wb_sel  in  4  byte selects.
- o_wb_stall  out  1  request not accepted this cycle.
- o_wb_ack  out  1  one-cycle completion pulse.
- o_wb_data  out  32  read data, valid with o_wb_ack.
- o_wb_err  out  1  one-cycle error pulse (timeout).
- o_mem_valid  out  1  native request pending.
- o_mem_addr  out  32  {i_wb_addr, 2'b00}.
- o_mem_wdata  out  32  captured write data.
- o_mem_wstrb  out  4  i_wb_sel on writes, 4'h0 on reads.
- i_mem_ready  in  1  native completion.
- i_mem_rdata  in  32  native read data, valid with i_mem_ready.

## Operation
- States:
  - IDLE: o_wb_stall=0.
  - BUSY: request issued, bus still attached.
  - ABORT: request issued, i_wb_cyc dropped.
- IDLE, with i_wb_cyc && i_wb_stb:
  - Capture addr, data, sel and we into o_mem_*.
  - If we && sel==0: no native request; o_wb_ack=1 next cycle; stay IDLE.
  - Otherwise: o_mem_valid<=1, o_wb_stall<=1, clear the counter, go to BUSY.
- BUSY, with i_mem_ready: o_mem_valid<=0, o_wb_stall<=0, o_wb_ack<=1. On reads o_wb_data<=i_mem_rdata. Go to IDLE.
- BUSY, i_wb_cyc low and no i_mem_ready: go to ABORT. o_mem_valid stays high, because the native protocol forbids withdrawing valid before ready.
- ABORT, with i_mem_ready: o_mem_valid<=0, o_wb_stall<=0, no ack or err. Go to IDLE.
- Timeout (TIMEOUT_CYCLES≠0): the counter increments every BUSY/ABORT cycle without ready. When it reaches TIMEOUT_CYCLES:
  - o_mem_valid<=0, go to IDLE.
  - In BUSY only, also o_wb_err<=1.
- o_mem_addr, o_mem_wdata and o_mem_wstrb are held stable while o_mem_valid=1.
- o_wb_data changes only on a read ack.

## Timing
- Reset (async, immediate): state IDLE; o_wb_stall, o_wb_ack, o_wb_err, o_mem_valid = 0; o_wb_data, o_mem_addr, o_mem_wdata, o_mem_wstrb = 0; counter = 0.
- Latency: stb accepted at cycle 0, o_mem_valid=1 at cycle 1. i_mem_ready at cycle k≥1 gives o_wb_ack at k+1. Minimum request-to-ack is 2 cycles.
- A zero-sel write acks at cycle 1.
- i_mem_ready is sampled only while o_mem_valid=1; otherwise it is ignored.
- o_wb_ack and o_wb_err are single-cycle pulses, mutually exclusive, and never asserted while i_wb_cyc=0 in the same cycle as the decision.
- Simultaneous events:
  - i_mem_ready in the same cycle the counter reaches TIMEOUT_CYCLES: ready wins, ack issued, no err.
  - i_wb_cyc falling in the same cycle as i_mem_ready: treated as abort completion, go to IDLE, no ack.
- Back-to-back: o_wb_stall falls in the cycle o_wb_ack rises, so the next request can be accepted in the ack cycle.
- Reset mid-transaction drops o_mem_valid asynchronously. Targets must tolerate this.

## Test plan
- Read: addr 30'h10, target ready 3 cycles after valid with rdata 32'hDEADBEEF -> o_mem_addr 32'h40, wstrb 0, o_wb_ack at cycle 5 with o_wb_data DEADBEEF, stall high cycles 1–4.
- Write: sel 4'b0011, data 32'h12345678, ready immediate -> o_mem_wstrb 4'b0011, wdata held, ack at cycle 2. Zero-sel write -> ack at cycle 1 and o_mem_valid never rises.
- Timeout, TIMEOUT_CYCLES=4, target silent -> o_wb_err one pulse, o_mem_valid low 4 cycles after it rose, no ack. With ready on the terminal cycle -> ack, no err.
- Abort: drop i_wb_cyc 1 cycle after issue, ready 5 cycles later -> o_mem_valid held until ready, no ack or err, stall cleared after ready, and the next request is accepted normally.
- Back-to-back reads with 0-wait target, plus async reset asserted mid-BUSY -> throughput of 1 per 2 cycles, no request lost; on reset all outputs go to 0 immediately and the first post-reset read completes correctly.
